// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter and its read-response router.
package dmem_arb_pkg;

   typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} arbState_t;
   typedef enum logic {OWN_PIPE = 1'b0, OWN_DBG = 1'b1} respOwner_t;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_resp_router.sv
// Remembers who issued the last accepted read and steers the memory's
// one-cycle-late read data back to that requester only.
module dmem_resp_router
   import dmem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        rdAccept,
   input  respOwner_t  rdOwner,
   input  logic [31:0] memRData,
   output logic        pRValid,
   output logic [31:0] pRData,
   output logic        dRValid,
   output logic [31:0] dRData
);

   respOwner_t respOwner;
   logic       respPend;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         respPend  <= 1'b0;
         respOwner <= OWN_PIPE;
      end else begin
         respPend <= rdAccept;
         if (rdAccept) respOwner <= rdOwner;
      end
   end

   always_comb begin
      pRValid = respPend && (respOwner == OWN_PIPE);
      dRValid = respPend && (respOwner == OWN_DBG);
      pRData  = pRValid ? memRData : '0;
      dRData  = dRValid ? memRData : '0;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (priority)
// and the debug/loader port, with a bounded wait before debug is forced in.
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        P_Req,
   input  logic        P_We,
   input  logic [31:0] P_Addr,
   input  logic [31:0] P_WData,
   input  logic        P_Byte,
   input  logic        P_Half,
   output logic        P_Gnt,
   output logic        P_RValid,
   output logic [31:0] P_RData,
   output logic        PipeStall,
   input  logic        D_Req,
   input  logic        D_We,
   input  logic [31:0] D_Addr,
   input  logic [31:0] D_WData,
   output logic        D_Gnt,
   output logic        D_RValid,
   output logic [31:0] D_RData,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_WData,
   output logic        Mem_We,
   output logic        Mem_Re,
   output logic        Mem_Byte,
   output logic        Mem_Half,
   input  logic [31:0] Mem_RData
);

   localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);

   arbState_t  state, nextState;
   logic [3:0] waitCnt, nextWaitCnt;
   logic       pGnt, dGnt, stall;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state   <= ST_NORMAL;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= nextWaitCnt;
      end
   end

   // Grants are gated by reset so every output reads 0 while Rst is low.
   always_comb begin
      nextState   = state;
      nextWaitCnt = waitCnt;
      pGnt        = 1'b0;
      dGnt        = 1'b0;
      stall       = 1'b0;
      if (Rst) begin
         case (state)
            ST_NORMAL: begin
               pGnt = P_Req;
               dGnt = D_Req && !P_Req;
               if (!D_Req || dGnt) begin
                  nextWaitCnt = '0;
               end else begin
                  if (waitCnt == WAIT_LAST) nextState = ST_FORCE;
                  nextWaitCnt = waitCnt + 4'd1;
               end
            end
            ST_FORCE: begin
               // Single forced slot: whether debug takes it or withdraws, return.
               dGnt        = D_Req;
               stall       = P_Req;
               nextState   = ST_NORMAL;
               nextWaitCnt = '0;
            end
         endcase
      end
   end

   always_comb begin
      Mem_Addr  = '0;
      Mem_WData = '0;
      Mem_We    = 1'b0;
      Mem_Re    = 1'b0;
      Mem_Byte  = 1'b0;
      Mem_Half  = 1'b0;
      if (pGnt) begin
         Mem_Addr  = P_Addr;
         Mem_WData = P_WData;
         Mem_We    = P_We;
         Mem_Re    = !P_We;
         Mem_Byte  = P_Byte;
         Mem_Half  = P_Half;
      end else if (dGnt) begin
         Mem_Addr  = D_Addr;
         Mem_WData = D_WData;
         Mem_We    = D_We;
         Mem_Re    = !D_We;
      end
   end

   assign P_Gnt     = pGnt;
   assign D_Gnt     = dGnt;
   assign PipeStall = stall;

   dmem_resp_router uRouter (
      .clk      (Clk),
      .rstN     (Rst),
      .rdAccept (Mem_Re),
      .rdOwner  (dGnt ? OWN_DBG : OWN_PIPE),
      .memRData (Mem_RData),
      .pRValid  (P_RValid),
      .pRData   (P_RData),
      .dRValid  (D_RValid),
      .dRData   (D_RData)
   );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter with a behavioural
// memory and an arbitration reference model.
module tb_data_mem_arbiter;

   localparam int LIMIT = 4;

   logic        Clk, Rst;
   logic        P_Req, P_We, P_Byte, P_Half, D_Req, D_We;
   logic [31:0] P_Addr, P_WData, D_Addr, D_WData;
   logic        P_Gnt, P_RValid, PipeStall, D_Gnt, D_RValid;
   logic [31:0] P_RData, D_RData, Mem_Addr, Mem_WData, Mem_RData;
   logic        Mem_We, Mem_Re, Mem_Byte, Mem_Half;

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0]  modelMem [64];
   logic [31:0]  ram [64];
   logic [31:0]  ramRData;
   logic [67:0]  memBus;
   logic [136:0] allOut;

   assign memBus = {Mem_Addr, Mem_WData, Mem_We, Mem_Re, Mem_Byte, Mem_Half};
   assign allOut = {P_Gnt, P_RValid, P_RData, PipeStall, D_Gnt, D_RValid, D_RData,
                    Mem_Addr, Mem_WData, Mem_We, Mem_Re, Mem_Byte, Mem_Half};
   assign Mem_RData = ramRData;

   data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .Clk(Clk), .Rst(Rst),
      .P_Req(P_Req), .P_We(P_We), .P_Addr(P_Addr), .P_WData(P_WData),
      .P_Byte(P_Byte), .P_Half(P_Half), .P_Gnt(P_Gnt), .P_RValid(P_RValid),
      .P_RData(P_RData), .PipeStall(PipeStall),
      .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_WData(D_WData),
      .D_Gnt(D_Gnt), .D_RValid(D_RValid), .D_RData(D_RData),
      .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_We(Mem_We), .Mem_Re(Mem_Re),
      .Mem_Byte(Mem_Byte), .Mem_Half(Mem_Half), .Mem_RData(Mem_RData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Single-port synchronous-read memory the arbiter drives.
   always @(posedge Clk) begin
      if (Mem_We) ram[Mem_Addr[7:2]] <= Mem_WData;
      if (Mem_Re) ramRData <= ram[Mem_Addr[7:2]];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive(input logic pReq, input logic pWe, input logic [31:0] pAddr,
                        input logic [31:0] pWData, input logic pByte, input logic pHalf,
                        input logic dReq, input logic dWe, input logic [31:0] dAddr,
                        input logic [31:0] dWData);
      P_Req = pReq; P_We = pWe; P_Addr = pAddr; P_WData = pWData;
      P_Byte = pByte; P_Half = pHalf;
      D_Req = dReq; D_We = dWe; D_Addr = dAddr; D_WData = dWData;
   endtask

   task automatic idleCycle();
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge Clk);
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      drive(1, 0, 32'h10, 32'h55, 1, 1, 1, 1, 32'h20, 32'h66);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      nChecks++; if (allOut !== '0) begin nFails++; $display("FAIL reset_outputs: got %h expected 0", allOut); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      Rst = 1'b1;
      #1;
      nChecks++; if ({P_Gnt, D_Gnt, PipeStall} !== 3'b000) begin nFails++; $display("FAIL reset_release_idle: got %b expected 000", {P_Gnt, D_Gnt, PipeStall}); end
      @(posedge Clk); #1;
      nChecks++; if ({P_RValid, D_RValid} !== 2'b00) begin nFails++; $display("FAIL reset_rvalid: got %b expected 00", {P_RValid, D_RValid}); end
   endtask

   // Debug-port word writes fill the whole memory; P size inputs are set to
   // prove they never leak onto a debug access.
   task automatic test_debug_write();
      logic [31:0] val, addr;
      for (int i = 0; i < 64; i++) begin
         val  = (i == 16) ? 32'h1234 : (i == 4) ? 32'hDEADBEEF : $urandom;
         addr = 32'(i * 4);
         @(negedge Clk);
         drive(0, 0, 0, 0, 1, 1, 1, 1, addr, val);
         #1;
         nChecks++; if ({D_Gnt, P_Gnt, PipeStall} !== 3'b100) begin nFails++; $display("FAIL dbg_wr_gnt[%0d]: got %b expected 100", i, {D_Gnt, P_Gnt, PipeStall}); end
         nChecks++; if (memBus !== {addr, val, 4'b1000}) begin nFails++; $display("FAIL dbg_wr_bus[%0d]: got %h expected %h", i, memBus, {addr, val, 4'b1000}); end
         modelMem[i] = val;
         @(posedge Clk); #1;
         nChecks++; if ({P_RValid, D_RValid} !== 2'b00) begin nFails++; $display("FAIL dbg_wr_rvalid[%0d]: got %b expected 00", i, {P_RValid, D_RValid}); end
      end
      idleCycle();
   endtask

   task automatic test_pipe_read();
      @(negedge Clk);
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      #1;
      nChecks++; if ({P_Gnt, D_Gnt} !== 2'b10) begin nFails++; $display("FAIL pread_gnt: got %b expected 10", {P_Gnt, D_Gnt}); end
      nChecks++; if (memBus !== {32'h10, 32'h0, 4'b0100}) begin nFails++; $display("FAIL pread_bus: got %h expected %h", memBus, {32'h10, 32'h0, 4'b0100}); end
      @(posedge Clk); #1;
      nChecks++; if (P_RValid !== 1'b1 || P_RData !== 32'hDEADBEEF) begin nFails++; $display("FAIL pread_data: got %b/%h expected 1/deadbeef", P_RValid, P_RData); end
      nChecks++; if (D_RValid !== 1'b0 || D_RData !== 32'h0) begin nFails++; $display("FAIL pread_dside: got %b/%h expected 0/0", D_RValid, D_RData); end
      idleCycle(); #1;
      nChecks++; if ({P_RValid, D_RValid} !== 2'b00) begin nFails++; $display("FAIL pread_after: got %b expected 00", {P_RValid, D_RValid}); end
   endtask

   task automatic test_contention();
      logic eP, eD;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         drive(1, 0, 32'(k * 4), 0, 0, 0, 1, 0, 32'h80, 0);
         #1;
         eP = (k != 5);
         eD = (k == 5);
         nChecks++; if ({P_Gnt, D_Gnt, PipeStall} !== {eP, eD, eD}) begin nFails++; $display("FAIL contend_gnt[%0d]: got %b expected %b", k, {P_Gnt, D_Gnt, PipeStall}, {eP, eD, eD}); end
         @(posedge Clk); #1;
         if (eD) begin
            nChecks++; if ({D_RValid, P_RValid, D_RData} !== {2'b10, modelMem[32]}) begin nFails++; $display("FAIL contend_dresp[%0d]: got %b%b/%h expected 10/%h", k, D_RValid, P_RValid, D_RData, modelMem[32]); end
         end else begin
            nChecks++; if ({P_RValid, D_RValid, P_RData} !== {2'b10, modelMem[k]}) begin nFails++; $display("FAIL contend_presp[%0d]: got %b%b/%h expected 10/%h", k, P_RValid, D_RValid, P_RData, modelMem[k]); end
         end
      end
      idleCycle();
   endtask

   task automatic test_alternating();
      @(negedge Clk);
      drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge Clk); #1;
      nChecks++; if ({P_RValid, D_RValid, P_RData, D_RData} !== {2'b10, modelMem[0], 32'h0}) begin nFails++; $display("FAIL alt_p: got %b%b/%h/%h expected 10/%h/0", P_RValid, D_RValid, P_RData, D_RData, modelMem[0]); end
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
      #1;
      nChecks++; if ({P_Gnt, D_Gnt, Mem_Re} !== 3'b011) begin nFails++; $display("FAIL alt_dgnt: got %b expected 011", {P_Gnt, D_Gnt, Mem_Re}); end
      @(posedge Clk); #1;
      nChecks++; if ({D_RValid, P_RValid, D_RData, P_RData} !== {2'b10, modelMem[1], 32'h0}) begin nFails++; $display("FAIL alt_d: got %b%b/%h/%h expected 10/%h/0", D_RValid, P_RValid, D_RData, P_RData, modelMem[1]); end
      idleCycle();
   endtask

   task automatic test_reset_midop();
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         drive(1, 0, 32'h8, 0, 0, 0, 1, 0, 32'hC, 0);
         @(posedge Clk);
      end
      @(negedge Clk);
      drive(1, 0, 32'h8, 0, 0, 0, 1, 0, 32'hC, 0);
      @(posedge Clk);
      Rst = 1'b0;
      #1;
      nChecks++; if (P_RValid !== 1'b0) begin nFails++; $display("FAIL midrst_rvalid: got %b expected 0", P_RValid); end
      nChecks++; if (allOut !== '0) begin nFails++; $display("FAIL midrst_outputs: got %h expected 0", allOut); end
      @(negedge Clk);
      nChecks++; if (allOut !== '0) begin nFails++; $display("FAIL midrst_hold: got %h expected 0", allOut); end
      Rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge Clk); #1;
      nChecks++; if (P_RValid !== 1'b0) begin nFails++; $display("FAIL midrst_release_rvalid: got %b expected 0", P_RValid); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge Clk);
         drive(1, 0, 32'h8, 0, 0, 0, 1, 0, 32'hC, 0);
         #1;
         nChecks++; if ({P_Gnt, D_Gnt} !== {k != 5, k == 5}) begin nFails++; $display("FAIL midrst_waitcnt[%0d]: got %b expected %b", k, {P_Gnt, D_Gnt}, {k != 5, k == 5}); end
         @(posedge Clk);
      end
      idleCycle();
   endtask

   task automatic test_force_drop();
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         drive(1, 0, 32'h14, 0, 0, 0, 1, 1, 32'h18, 32'hAAAA5555);
         #1;
         nChecks++; if ({P_Gnt, D_Gnt} !== 2'b10) begin nFails++; $display("FAIL drop_pre[%0d]: got %b expected 10", k, {P_Gnt, D_Gnt}); end
         @(posedge Clk);
      end
      @(negedge Clk);
      drive(1, 0, 32'h14, 0, 0, 0, 0, 1, 32'h18, 32'hAAAA5555);
      #1;
      nChecks++; if ({P_Gnt, D_Gnt, PipeStall} !== 3'b001) begin nFails++; $display("FAIL drop_force_gnt: got %b expected 001", {P_Gnt, D_Gnt, PipeStall}); end
      nChecks++; if (memBus !== '0) begin nFails++; $display("FAIL drop_force_bus: got %h expected 0", memBus); end
      @(posedge Clk); #1;
      nChecks++; if ({P_RValid, D_RValid} !== 2'b00) begin nFails++; $display("FAIL drop_rvalid: got %b expected 00", {P_RValid, D_RValid}); end
      @(negedge Clk);
      drive(1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0);
      #1;
      nChecks++; if ({P_Gnt, D_Gnt, PipeStall} !== 3'b100) begin nFails++; $display("FAIL drop_after: got %b expected 100", {P_Gnt, D_Gnt, PipeStall}); end
      @(posedge Clk);
      idleCycle();
   endtask

   // Reference: debug is owed a forced slot once it has been refused LIMIT
   // consecutive cycles; otherwise the pipeline always wins.
   task automatic test_random();
      int          starve;
      logic        pReq, pWe, pByte, pHalf, dReq, dWe, forced, eP, eD, eS, expPV, expDV;
      logic [31:0] pAddr, pWData, dAddr, dWData, expData;
      logic [67:0] eBus;
      starve = 0;
      for (int c = 0; c < 400; c++) begin
         pReq   = ($urandom_range(3) != 0);
         pWe    = ($urandom_range(2) == 0);
         pByte  = 1'($urandom_range(1));
         pHalf  = 1'($urandom_range(1));
         pAddr  = {24'h0, 6'($urandom_range(63)), 2'b00};
         pWData = $urandom;
         dReq   = 1'($urandom_range(1));
         dWe    = ($urandom_range(2) == 0);
         dAddr  = {24'h0, 6'($urandom_range(63)), 2'b00};
         dWData = $urandom;
         forced = (starve >= LIMIT);
         eP = forced ? 1'b0 : pReq;
         eD = forced ? dReq : (dReq && !pReq);
         eS = forced && pReq;
         eBus = eP ? {pAddr, pWData, pWe, !pWe, pByte, pHalf}
              : eD ? {dAddr, dWData, dWe, !dWe, 2'b00} : '0;
         @(negedge Clk);
         drive(pReq, pWe, pAddr, pWData, pByte, pHalf, dReq, dWe, dAddr, dWData);
         #1;
         nChecks++; if ({P_Gnt, D_Gnt, PipeStall} !== {eP, eD, eS}) begin nFails++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, {P_Gnt, D_Gnt, PipeStall}, {eP, eD, eS}); end
         nChecks++; if (memBus !== eBus) begin nFails++; $display("FAIL rand_bus[%0d]: got %h expected %h", c, memBus, eBus); end
         expPV   = eP && !pWe;
         expDV   = eD && !dWe;
         expData = eP ? modelMem[pAddr[7:2]] : modelMem[dAddr[7:2]];
         if (eP && pWe) modelMem[pAddr[7:2]] = pWData;
         if (eD && dWe) modelMem[dAddr[7:2]] = dWData;
         if (forced) starve = 0;
         else if (dReq && !eD) starve++;
         else starve = 0;
         @(posedge Clk); #1;
         nChecks++; if ({P_RValid, P_RData} !== {expPV, expPV ? expData : 32'h0}) begin nFails++; $display("FAIL rand_presp[%0d]: got %b/%h expected %b/%h", c, P_RValid, P_RData, expPV, expPV ? expData : 32'h0); end
         nChecks++; if ({D_RValid, D_RData} !== {expDV, expDV ? expData : 32'h0}) begin nFails++; $display("FAIL rand_dresp[%0d]: got %b/%h expected %b/%h", c, D_RValid, D_RData, expDV, expDV ? expData : 32'h0); end
      end
      idleCycle();
   endtask

   initial begin
      Rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_debug_write();
      test_pipe_read();
      test_contention();
      test_alternating();
      test_reset_midop();
      test_force_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port, synchronous-read data memory between the pipeline MEM stage and the debug/loader port, with pipeline priority and a bounded-wait guarantee for debug. It sits between the MEM stage and the DataMemory instance. It grants at most one access per cycle and routes each read response back to the requester that issued it. It also raises a pipeline stall whenever the MEM stage is denied the memory.

## Interface
- STARVE_LIMIT, 4: consecutive denied debug cycles before debug is forced through (1..15).
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- P_Req  in  1  MEM-stage access request.
- P_We  in  1  MEM-stage write (0 = read).
- P_Addr  in  32  MEM-stage byte address.
- P_WData  in  32  MEM-stage write data.
- P_Byte, P_Half  in  1 each  MEM-stage access size.
- P_Gnt  out  1  MEM-stage access accepted this cycle.
- P_RValid  out  1  MEM-stage read data valid.
- P_RData  out  32  MEM-stage read data.
- PipeStall  out  1  freezes the pipeline.
- D_Req  in  1  debug request, held until granted.
- D_We  in  1  debug write.
- D_Addr  in  32  debug address.
- D_WData  in  32  debug write data.
- D_Gnt  out  1  debug access accepted.
- D_RValid  out  1  debug read data valid.
- D_RData  out  32  debug read data.
- Mem_Addr  out  32  memory address.
- Mem_WData  out  32  memory write data.
- Mem_We, Mem_Re  out  1 each  memory write / read strobes.
- Mem_Byte, Mem_Half  out  1 each  memory access size.
- Mem_RData  in  32  memory read data, valid one cycle after the Mem_Re cycle.

## Operation
- An access is accepted on a rising edge where Req and Gnt are both high.
- Gnt is combinational from the requests and the FSM state.
- FSM states:
  - NORMAL:
    - P_Req wins whenever it is asserted.
    - D is granted only when P_Req=0.
    - WaitCnt increments each cycle with D_Req=1 and D_Gnt=0.
    - When WaitCnt reaches STARVE_LIMIT-1 on such a cycle, the next state is FORCE.
  - FORCE:
    - D_Gnt = D_Req and P_Gnt = 0.
    - PipeStall = P_Req.
    - On D acceptance: go to NORMAL and clear WaitCnt.
    - If D_Req drops: go to NORMAL, clear WaitCnt, and issue no access.
- WaitCnt clears on any D acceptance.
- WaitCnt clears on any cycle with D_Req=0.
- In NORMAL, PipeStall = 0.
- Memory outputs:
  - The Mem_* outputs mirror the granted port.
  - Mem_Re = Gnt & ~We.
  - Mem_We = Gnt & We.
  - Debug accesses are always word size: Mem_Byte = Mem_Half = 0.
  - With no grant, all strobes are 0 and Mem_Addr/Mem_WData are 0.
- Response routing:
  - The owner of an accepted read is registered: RespOwner, RespPend.
  - In the following cycle, the owner's RValid = 1 and its RData = Mem_RData.
  - The non-owner's RData = 0.
- A write produces no RValid.
- Back-to-back reads, including reads alternating between owners, are legal every cycle.

## Timing
- Grant latency is 0 cycles; read data latency is 1 cycle after acceptance.
- Worst-case debug wait is STARVE_LIMIT cycles from D_Req assertion to D_Gnt.
- PipeStall covers exactly the FORCE cycles with P_Req=1, which is 1 cycle per forced access.
- Reset values and behaviour while Rst=0:
  - State NORMAL, WaitCnt 0, RespPend 0.
  - All outputs are 0, including the combinational Gnt and Mem_* outputs.
- Reset asserted mid-operation: a pending read response is dropped, and RValid stays 0 after release.
- Simultaneous P_Req and D_Req on the cycle WaitCnt hits its limit: P is granted that cycle, and FORCE takes effect the next cycle.
- STARVE_LIMIT=1: D is forced on the cycle after any denied request.

## Structure
- Shared package dmem_arb_pkg holds:
  - State encodings ST_NORMAL and ST_FORCE.
  - Owner encodings OWN_PIPE and OWN_DBG.
  - The default STARVE_LIMIT.
- One sub-module, dmem_resp_router, covers:
  - The RespOwner/RespPend registers.
  - RValid/RData steering.
- FSM, WaitCnt and grant logic live in the top module.

## Test plan
- Pipeline only: read at 0x10 with memory holding 0xDEADBEEF.
  - P_Gnt=1 in cycle N.
  - P_RValid=1 and P_RData=0xDEADBEEF in N+1.
  - D_RValid=0 throughout.
- Debug only: write 0x1234 at 0x40.
  - Mem_We=1, Mem_Addr=0x40, Mem_Byte=Mem_Half=0.
  - No RValid in the following cycle.
- Contention, STARVE_LIMIT=4, P_Req and D_Req held high:
  - P granted for 4 cycles.
  - 5th cycle: D_Gnt=1, P_Gnt=0, PipeStall=1.
  - 6th cycle: P granted again, PipeStall=0.
- Alternating reads P@0x0 then D@0x4 on consecutive cycles: each RValid appears one cycle later on the correct port only, with the correct data.
- Reset asserted the cycle after a P read acceptance:
  - P_RValid never asserts.
  - All outputs are 0 while Rst=0.
  - WaitCnt restarts from 0.
- D_Req dropped while in FORCE: no access is issued, state returns to NORMAL, and a P request is granted the next cycle.
